// File: rtl/median_pkg.sv
// median_pkg: state encoding and arithmetic helpers shared by the median blocks.
package median_pkg;
  typedef enum logic [1:0] {ST_LOAD, ST_SCAN, ST_DECIDE, ST_OUT} state_t;
  localparam int MID_W = 32;
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction
  function automatic int pass_width(input int data_w);
    return $clog2(data_w + 2) + 1;
  endfunction
  function automatic logic [MID_W-1:0] mid(input logic [MID_W-1:0] a, input logic [MID_W-1:0] b);
    logic [MID_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[MID_W:1];
  endfunction
endpackage

// File: rtl/median_frame_ram.sv
// median_frame_ram: single-port frame buffer with write enable and registered read.
module median_frame_ram #(
  parameter int DATA_W = 8,
  parameter int FRAME_LEN = 32,
  parameter int ADDR_W = $clog2(FRAME_LEN)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [FRAME_LEN];
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/median_select_iter.sv
// median_select_iter: k-th order statistic of a buffered frame by repeated value-range bisection.
module median_select_iter
  import median_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FRAME_LEN = 32,
  parameter int ADDR_W = $clog2(FRAME_LEN),
  parameter int CNT_W = cnt_width(FRAME_LEN),
  parameter int PASS_W = pass_width(DATA_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  in_rank,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PASS_W-1:0] out_passes,
  output logic              busy
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] wr_addr, ram_addr;
  logic [CNT_W-1:0] sc, k, kclamp, lower_cnt, equal_cnt, larger_cnt, le;
  logic [DATA_W-1:0] rdata, fmin, fmax, nmin, nmax, lo, hi, pivot, l_min, l_max, g_min, g_max;
  logic [PASS_W-1:0] passes;
  logic take, first, last_load, scan_done, hit, go_low, found, start;

  function automatic logic [DATA_W-1:0] pmid(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return DATA_W'(mid(MID_W'(a), MID_W'(b)));
  endfunction

  median_frame_ram #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) u_ram (
    .clock(clock),
    .we(take),
    .addr(ram_addr),
    .wdata(in_data),
    .rdata(rdata)
  );

  assign in_ready  = state == ST_LOAD;
  assign busy      = state != ST_LOAD || wr_addr != '0;
  assign take      = in_valid && in_ready;
  assign first     = wr_addr == '0;
  assign last_load = take && wr_addr == ADDR_W'(FRAME_LEN - 1);
  assign ram_addr  = in_ready ? wr_addr : ADDR_W'(sc);
  assign kclamp    = in_rank > CNT_W'(FRAME_LEN - 1) ? CNT_W'(FRAME_LEN - 1) : in_rank;
  assign nmin      = (first || in_data < fmin) ? in_data : fmin;
  assign nmax      = (first || in_data > fmax) ? in_data : fmax;
  // sc==0 is the address-issue cycle; read data for address sc-1 arrives at sc
  assign scan_done = sc == CNT_W'(FRAME_LEN);
  assign hit       = state == ST_SCAN && sc != '0 && rdata >= lo && rdata <= hi;
  assign le        = lower_cnt + equal_cnt;
  assign go_low    = lower_cnt > k;
  assign found     = !go_low && le > k;
  assign start     = last_load || (state == ST_DECIDE && !found);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_LOAD;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    state_nx = state == ST_LOAD   ? (last_load ? ST_SCAN : ST_LOAD) :
               state == ST_SCAN   ? (scan_done ? ST_DECIDE : ST_SCAN) :
               state == ST_DECIDE ? (found ? ST_OUT : ST_SCAN) :
                                    (out_ready ? ST_LOAD : ST_OUT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_addr <= '0;
      sc <= '0;
      k <= '0;
      lower_cnt <= '0;
      equal_cnt <= '0;
      larger_cnt <= '0;
      fmin <= '0;
      fmax <= '0;
      lo <= '0;
      hi <= '0;
      pivot <= '0;
      l_min <= '0;
      l_max <= '0;
      g_min <= '0;
      g_max <= '0;
      passes <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_passes <= '0;
    end else begin
      if (take) begin
        wr_addr <= last_load ? '0 : wr_addr + ADDR_W'(1);
        fmin <= nmin;
        fmax <= nmax;
        if (first) k <= kclamp;
      end
      if (last_load) begin
        lo <= nmin;
        hi <= nmax;
        pivot <= pmid(nmin, nmax);
        passes <= '0;
      end
      if (start) begin
        sc <= '0;
        lower_cnt <= '0;
        equal_cnt <= '0;
        larger_cnt <= '0;
        l_min <= '1;
        l_max <= '0;
        g_min <= '1;
        g_max <= '0;
      end else if (state == ST_SCAN) begin
        sc <= sc + CNT_W'(1);
        if (hit && rdata < pivot) begin
          lower_cnt <= lower_cnt + CNT_W'(1);
          l_min <= rdata < l_min ? rdata : l_min;
          l_max <= rdata > l_max ? rdata : l_max;
        end else if (hit && rdata == pivot) begin
          equal_cnt <= equal_cnt + CNT_W'(1);
        end else if (hit) begin
          larger_cnt <= larger_cnt + CNT_W'(1);
          g_min <= rdata < g_min ? rdata : g_min;
          g_max <= rdata > g_max ? rdata : g_max;
        end
      end
      if (state == ST_DECIDE) begin
        passes <= passes + PASS_W'(1);
        if (go_low) begin
          lo <= l_min;
          hi <= l_max;
          pivot <= pmid(l_min, l_max);
        end else if (found) begin
          out_data <= pivot;
          out_valid <= 1'b1;
          out_passes <= passes + PASS_W'(1);
        end else begin
          k <= k - le;
          lo <= g_min;
          hi <= g_max;
          pivot <= pmid(g_min, g_max);
        end
      end
      if (state == ST_OUT && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_median_select_iter.sv
// tb_median_select_iter: vector table, hand sequences and randomized frames against a queue-based model.
module tb_median_select_iter;
  localparam int DW = 8;
  localparam int FL = 8;
  localparam int CW = 4;
  localparam int PW = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [CW-1:0] in_rank = '0;
  logic [DW-1:0] out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [PW-1:0] out_passes;
  logic busy;

  int n_chk = 0;
  int n_fail = 0;
  int lat;

  median_select_iter #(.DATA_W(DW), .FRAME_LEN(FL)) dut (
    .clock(clock),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_rank(in_rank),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_passes(out_passes),
    .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] f;
    int rank;
    int exp_data;
    int exp_passes;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a, b, c, d, e, f, g, h);
    return {8'(h), 8'(g), 8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Sorted-order answer for the value, set-narrowing bisection for the pass count.
  function automatic int ref_val(input logic [63:0] f, input int rank);
    int q[$];
    for (int i = 0; i < FL; i++) q.push_back(int'(f[8*i +: 8]));
    q.sort();
    return q[rank > FL - 1 ? FL - 1 : rank];
  endfunction

  function automatic int ref_passes(input logic [63:0] f, input int rank);
    int q[$];
    int l[$];
    int g[$];
    int e, mn, mx, p, k, n;
    for (int i = 0; i < FL; i++) q.push_back(int'(f[8*i +: 8]));
    k = rank > FL - 1 ? FL - 1 : rank;
    n = 0;
    for (int it = 0; it < 20; it++) begin
      mn = 1000;
      mx = -1;
      foreach (q[j]) begin
        if (q[j] < mn) mn = q[j];
        if (q[j] > mx) mx = q[j];
      end
      p = (mn + mx) / 2;
      l.delete();
      g.delete();
      e = 0;
      foreach (q[j]) begin
        if (q[j] < p) l.push_back(q[j]);
        else if (q[j] == p) e++;
        else g.push_back(q[j]);
      end
      n++;
      if (l.size() > k) q = l;
      else if (l.size() + e > k) return n;
      else begin
        k -= l.size() + e;
        q = g;
      end
    end
    return -1;
  endfunction

  task automatic load_frame(input logic [63:0] f, input int rank);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clock);
      w++;
    end
    chk("in_ready_before_load", int'(in_ready), 1);
    lat = 0;
    for (int i = 0; i < FL; i++) begin
      in_data = f[8*i +: 8];
      in_rank = CW'(rank);
      in_valid = 1'b1;
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (i == 0) chk("busy_after_first", int'(busy), 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    while (!out_valid && lat < 1000) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    chk("out_valid_within_budget", int'(out_valid), 1);
  endtask

  task automatic accept(input int hold, input int exp_data, input int exp_passes);
    for (int i = 0; i < hold; i++) begin
      chk("hold_stable", int'({out_valid, in_ready, out_data, out_passes}),
          int'({1'b1, 1'b0, 8'(exp_data), 5'(exp_passes)}));
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    chk("out_valid_dropped", int'(out_valid), 0);
    chk("in_ready_after_accept", int'(in_ready), 1);
    chk("busy_after_accept", int'(busy), 0);
  endtask

  task automatic run_check(input string name, input logic [63:0] f, input int rank,
                           input int exp_data, input int exp_passes, input int hold);
    load_frame(f, rank);
    wait_result();
    chk({name, "_data"}, int'(out_data), exp_data);
    chk({name, "_passes"}, int'(out_passes), exp_passes);
    chk({name, "_latency"}, lat, FL + exp_passes * (FL + 2));
    chk({name, "_pass_bound"}, int'(out_passes <= PW'(DW + 1)), 1);
    accept(hold, exp_data, exp_passes);
  endtask

  initial begin
    vec_t vecs[7];
    logic [63:0] f1, fr;
    int rk;
    f1 = pk(7, 3, 9, 1, 5, 8, 2, 6);
    vecs[0] = '{f1, 4, 6, 3};
    vecs[1] = '{pk(42, 42, 42, 42, 42, 42, 42, 42), 4, 42, 1};
    vecs[2] = '{f1, 0, 1, 3};
    vecs[3] = '{f1, 7, 9, 4};
    vecs[4] = '{f1, 12, 9, 4};
    vecs[5] = '{pk(0, 255, 0, 255, 0, 255, 0, 255), 4, 255, 2};
    vecs[6] = '{pk(0, 255, 0, 255, 0, 255, 0, 255), 3, 0, 2};

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_passes", int'(out_passes), 0);
    chk("rst_busy", int'(busy), 0);

    for (int i = 0; i < 7; i++)
      run_check($sformatf("vec%0d", i), vecs[i].f, vecs[i].rank, vecs[i].exp_data, vecs[i].exp_passes, 0);

    load_frame(pk(42, 42, 42, 42, 42, 42, 42, 42), 4);
    wait_result();
    chk("const_latency_18", lat, 18);
    accept(0, 42, 1);

    load_frame(f1, 4);
    wait_result();
    accept(10, 6, 3);
    run_check("back_to_back", pk(0, 255, 0, 255, 0, 255, 0, 255), 3, 0, 2, 0);

    load_frame(f1, 4);
    repeat (13) @(posedge clock);
    @(negedge clock);
    chk("busy_mid_scan", int'(busy), 1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    run_check("after_abort", f1, 7, 9, 4, 0);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < FL; i++)
        fr[8*i +: 8] = 8'((t % 3 == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255));
      rk = $urandom_range(0, 15);
      run_check($sformatf("rand%0d", t), fr, rk, ref_val(fr, rk), ref_passes(fr, rk), t % 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
